// File: rtl/s2_rx_bank_pkg.sv
// Shared types and frame sizing for the S2 receive bank.
// S2_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package s2_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WRITE,
      ERROR
   } rx_state_t;

`ifdef S2_RX_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int frame_w(input int addr_w, input int data_w);
      return addr_w + data_w + PAR_W;
   endfunction

endpackage

// File: rtl/s2_rx_bank_if.sv
// Serial link and register-bank port bundle for the S2 receiver.
interface s2_rx_bank_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 18
);
   logic              sen;
   logic              sd;
   logic              rb_rw;
   logic [ADDR_W-1:0] rb_a;
   logic [DATA_W-1:0] rb_d;
   logic [DATA_W-1:0] rb_q;

   modport master (
      output sen, sd, rb_q,
      input  rb_rw, rb_a, rb_d
   );

   modport slave (
      input  sen, sd, rb_q,
      output rb_rw, rb_a, rb_d
   );
endinterface

// File: rtl/s2_rx_bank_shift.sv
// Frame deserialiser: MSB-first shift register, saturating bit counter
// and running parity over every received bit.
module s2_rx_shift #(
   parameter int FRAME_W = 21,
   parameter int CNT_W   = $clog2(FRAME_W + 2)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic               sd,
   output logic [FRAME_W-1:0] sreg,
   output logic [CNT_W-1:0]   cnt,
   output logic               par
);

   // Counter stops one past a full frame so over-long frames never alias.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg <= '0;
         cnt  <= '0;
         par  <= 1'b0;
      end else if (load) begin
         sreg <= {{(FRAME_W-1){1'b0}}, sd};
         cnt  <= CNT_W'(1);
         par  <= sd;
      end else if (shift) begin
         sreg <= {sreg[FRAME_W-2:0], sd};
         par  <= par ^ sd;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/s2_rx_bank.sv
// S2 serial-to-register-bank receiver: FSM, bank write port, coverage bitmap
// and error counter. Parity checking is enabled by defining S2_RX_PARITY_EN.
module s2_rx_bank
   import s2_rx_pkg::*;
#(
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 18,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   s2_rx_bank_if.slave         bus,
   output logic                done,
   output logic                frame_err,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam int DEPTH   = 2 ** ADDR_W;

   rx_state_t         state;
   rx_state_t         next_state;
   logic              load;
   logic              shift;
   logic              par;
   logic              par_ok;
   logic              len_ok;
   logic              spare_unused;
   logic [FRAME_W-1:0] sreg;
   logic [CNT_W-1:0]  cnt;
   logic [DEPTH-1:0]  bitmap;
   logic [ADDR_W-1:0] frame_a;
   logic [DATA_W-1:0] frame_d;

   s2_rx_shift #(
      .FRAME_W (FRAME_W),
      .CNT_W   (CNT_W)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .sd    (bus.sd),
      .sreg  (sreg),
      .cnt   (cnt),
      .par   (par)
   );

   // Bank read data is never consumed; the parity bit only matters through par.
   assign spare_unused = ^{bus.rb_q, sreg};

   assign frame_a = sreg[FRAME_W-1 -: ADDR_W];
   assign frame_d = sreg[PAR_W +: DATA_W];
   assign len_ok  = (cnt == CNT_W'(FRAME_W));
   assign par_ok  = (PAR_W == 0) || !par;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // WRITE and ERROR last one cycle and may already capture the next frame's first bit.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift      = 1'b0;
      case (state)
         IDLE, WRITE, ERROR: begin
            if (!bus.sen) begin
               load       = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         SHIFT: begin
            if (!bus.sen) begin
               shift = 1'b1;
            end else if (len_ok && par_ok) begin
               next_state = WRITE;
            end else begin
               next_state = ERROR;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the WRITE/ERROR cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rb_rw <= 1'b1;
         bus.rb_a  <= '0;
         bus.rb_d  <= '0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
         bitmap    <= '0;
         done      <= 1'b0;
      end else begin
         bus.rb_rw <= (next_state != WRITE);
         frame_err <= (next_state == ERROR);
         if (next_state == WRITE) begin
            bus.rb_a        <= frame_a;
            bus.rb_d        <= frame_d;
            bitmap[frame_a] <= 1'b1;
         end
         if ((next_state == ERROR) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
         if (&bitmap) begin
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_s2_rx_bank.sv
// Scoreboard bench for s2_rx_bank; expected bank writes are queued as frames
// are sent and checked by a write monitor. Honours S2_RX_PARITY_EN.
module tb_s2_rx_bank;
   import s2_rx_pkg::*;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 18;
   localparam int ERRCNT_W = 8;
   localparam int FW       = frame_w(ADDR_W, DATA_W);
   localparam int LONG_LEN = FW + (1 << $clog2(FW + 2));

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                done;
   logic                frame_err;
   logic [ERRCNT_W-1:0] err_cnt;

   int  checks      = 0;
   int  failures    = 0;
   int  write_cnt   = 0;
   int  err_pulses  = 0;
   wr_t exp_q[$];
   wr_t exp_w;

   s2_rx_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   s2_rx_bank #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .ERRCNT_W (ERRCNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .done      (done),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Every write strobe seen on a falling edge must match the oldest queued frame.
   always @(negedge clk) begin
      if (rst) begin
         if (frame_err === 1'b1) err_pulses++;
         if (bus.rb_rw === 1'b0) begin
            write_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_write got a=%0d d=0x%0h expected no write", bus.rb_a, bus.rb_d);
            end else begin
               exp_w = exp_q.pop_front();
               if ({bus.rb_a, bus.rb_d} !== exp_w) begin
                  failures++;
                  $display("[TB] FAIL write_data got a=%0d d=0x%0h expected a=%0d d=0x%0h",
                           bus.rb_a, bus.rb_d, exp_w.a, exp_w.d);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] make_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
`ifdef S2_RX_PARITY_EN
      return 64'({a, d, ^{a, d}});
`else
      return 64'({a, d});
`endif
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int nbits, input logic [63:0] bits);
      for (int i = nbits - 1; i >= 0; i--) begin
         @(posedge clk);
         #1;
         bus.sen = 1'b0;
         bus.sd  = bits[i];
      end
      @(posedge clk);
      #1;
      bus.sen = 1'b1;
      bus.sd  = 1'b0;
   endtask

   task automatic send_good(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back('{a: a, d: d});
      applyStimulus(FW, make_frame(a, d));
   endtask

   task automatic do_reset();
      bus.sen = 1'b1;
      rst     = 1'b0;
      idle(3);
      rst     = 1'b1;
      idle(2);
      exp_q.delete();
   endtask

   task automatic test_reset();
      idle(2);
      checks += 6;
      if (bus.rb_rw !== 1'b1) begin failures++; $display("[TB] FAIL reset_rb_rw got=%0b expected=1", bus.rb_rw); end
      if (bus.rb_a !== '0) begin failures++; $display("[TB] FAIL reset_rb_a got=%0d expected=0", bus.rb_a); end
      if (bus.rb_d !== '0) begin failures++; $display("[TB] FAIL reset_rb_d got=0x%0h expected=0", bus.rb_d); end
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b expected=0", done); end
      if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%0b expected=0", frame_err); end
      if (err_cnt !== '0) begin failures++; $display("[TB] FAIL reset_err_cnt got=%0d expected=0", err_cnt); end
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_single_write();
      int w;
      w = write_cnt;
      send_good(3'd5, 18'h2A5A5);
      @(negedge clk);
      checks++;
      if (bus.rb_rw !== 1'b1) begin failures++; $display("[TB] FAIL early_strobe got=%0b expected=1", bus.rb_rw); end
      @(negedge clk);
      checks++;
      if (bus.rb_rw !== 1'b0) begin failures++; $display("[TB] FAIL strobe_latency got=%0b expected=0", bus.rb_rw); end
      idle(3);
      checks += 5;
      if (write_cnt - w != 1) begin failures++; $display("[TB] FAIL single_write_count got=%0d expected=1", write_cnt - w); end
      if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL single_pending got=%0d expected=0", exp_q.size()); end
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL single_done got=%0b expected=0", done); end
      if (bus.rb_a !== 3'd5) begin failures++; $display("[TB] FAIL single_hold_a got=%0d expected=5", bus.rb_a); end
      if (bus.rb_d !== 18'h2A5A5) begin failures++; $display("[TB] FAIL single_hold_d got=0x%0h expected=0x2a5a5", bus.rb_d); end
   endtask

   task automatic test_length_errors();
      int w, p;
      w = write_cnt;
      p = err_pulses;
      applyStimulus(FW - 1, {$urandom, $urandom});
      idle(2);
      applyStimulus(FW + 1, {$urandom, $urandom});
      idle(2);
      checks += 5;
      if (err_pulses - p != 2) begin failures++; $display("[TB] FAIL len_err_pulses got=%0d expected=2", err_pulses - p); end
      if (err_cnt !== 8'd2) begin failures++; $display("[TB] FAIL len_err_cnt got=%0d expected=2", err_cnt); end
      if (write_cnt != w) begin failures++; $display("[TB] FAIL len_err_write got=%0d expected=%0d", write_cnt, w); end
      if (bus.rb_a !== 3'd5) begin failures++; $display("[TB] FAIL len_err_hold_a got=%0d expected=5", bus.rb_a); end
      if (bus.rb_d !== 18'h2A5A5) begin failures++; $display("[TB] FAIL len_err_hold_d got=0x%0h expected=0x2a5a5", bus.rb_d); end
      // Long enough that a wrapping bit counter would land back on a legal length.
      applyStimulus(LONG_LEN, {$urandom, $urandom});
      idle(2);
      checks += 2;
      if (err_cnt !== 8'd3) begin failures++; $display("[TB] FAIL long_err_cnt got=%0d expected=3", err_cnt); end
      if (write_cnt != w) begin failures++; $display("[TB] FAIL long_err_write got=%0d expected=%0d", write_cnt, w); end
   endtask

   task automatic test_back_to_back();
      int w;
      do_reset();
      w = write_cnt;
      for (int a = 0; a < 8; a++) begin
         send_good(ADDR_W'(a), DATA_W'($urandom));
         checks++;
         if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_early a=%0d got=%0b expected=0", a, done); end
      end
      @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (bus.rb_rw !== 1'b0) begin failures++; $display("[TB] FAIL b2b_last_strobe got=%0b expected=0", bus.rb_rw); end
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_in_write got=%0b expected=0", done); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done_after got=%0b expected=1", done); end
      idle(2);
      checks += 2;
      if (write_cnt - w != 8) begin failures++; $display("[TB] FAIL b2b_writes got=%0d expected=8", write_cnt - w); end
      if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL b2b_pending got=%0d expected=0", exp_q.size()); end
      send_good(3'd2, 18'h3FFFF);
      idle(3);
      checks += 2;
      if (done !== 1'b1) begin failures++; $display("[TB] FAIL done_sticky got=%0b expected=1", done); end
      if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL after_done_pending got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_partial_fill();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int a = 0; a < 7; a++) begin
            send_good(ADDR_W'(a), DATA_W'($urandom));
         end
      end
      idle(3);
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL partial_done got=%0b expected=0", done); end
      send_good(3'd7, 18'h00777);
      idle(3);
      checks += 2;
      if (done !== 1'b1) begin failures++; $display("[TB] FAIL partial_done_final got=%0b expected=1", done); end
      if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL partial_pending got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe();
      int w, p;
      do_reset();
      w = write_cnt;
      p = err_pulses;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.sen = 1'b0;
         bus.sd  = 1'($urandom);
      end
      rst     = 1'b0;
      bus.sen = 1'b1;
      idle(2);
      rst     = 1'b1;
      idle(1);
      send_good(3'd3, 18'h01234);
      idle(3);
      checks += 5;
      if (write_cnt - w != 1) begin failures++; $display("[TB] FAIL midrst_writes got=%0d expected=1", write_cnt - w); end
      if (err_pulses != p) begin failures++; $display("[TB] FAIL midrst_err_pulses got=%0d expected=%0d", err_pulses, p); end
      if (err_cnt !== '0) begin failures++; $display("[TB] FAIL midrst_err_cnt got=%0d expected=0", err_cnt); end
      if (bus.rb_a !== 3'd3) begin failures++; $display("[TB] FAIL midrst_a got=%0d expected=3", bus.rb_a); end
      if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL midrst_pending got=%0d expected=0", exp_q.size()); end
   endtask

   task automatic test_err_saturation();
      int p;
      do_reset();
      p = err_pulses;
      for (int i = 0; i < 254; i++) applyStimulus(1, 64'($urandom));
      idle(2);
      checks++;
      if (err_cnt !== 8'd254) begin failures++; $display("[TB] FAIL sat_below got=%0d expected=254", err_cnt); end
      for (int i = 0; i < 40; i++) applyStimulus(1, 64'($urandom));
      idle(2);
      checks += 2;
      if (err_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL sat_cnt got=%0d expected=255", err_cnt); end
      if (err_pulses - p != 294) begin failures++; $display("[TB] FAIL sat_pulses got=%0d expected=294", err_pulses - p); end
   endtask

`ifdef S2_RX_PARITY_EN
   task automatic test_parity();
      int w, p;
      do_reset();
      w = write_cnt;
      p = err_pulses;
      send_good(3'd1, 18'h00001);
      idle(3);
      applyStimulus(FW, {3'd1, 18'h00001, 1'b1});
      idle(3);
      checks += 4;
      if (write_cnt - w != 1) begin failures++; $display("[TB] FAIL parity_writes got=%0d expected=1", write_cnt - w); end
      if (err_pulses - p != 1) begin failures++; $display("[TB] FAIL parity_err_pulses got=%0d expected=1", err_pulses - p); end
      if (err_cnt !== 8'd1) begin failures++; $display("[TB] FAIL parity_err_cnt got=%0d expected=1", err_cnt); end
      if (bus.rb_d !== 18'h00001) begin failures++; $display("[TB] FAIL parity_hold_d got=0x%0h expected=0x1", bus.rb_d); end
   endtask
`endif

   initial begin
      bus.sen  = 1'b1;
      bus.sd   = 1'b0;
      bus.rb_q = '0;
      test_reset();
      test_single_write();
      test_length_errors();
      test_back_to_back();
      test_partial_fill();
      test_reset_midframe();
      test_err_saturation();
`ifdef S2_RX_PARITY_EN
      test_parity();
`endif
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/s2_rx_bank.md
# s2_rx_bank

Parametrised serial-to-register-bank receiver: the next generation of the S2 receive stage. Deserialises address+data frames from the `sen`/`sd` serial link, validates frame length (and optionally parity), and writes each good word into the external register bank through a single-cycle write strobe. Raises a sticky `done` once every bank address has been written at least once, and reports malformed frames on a dedicated error pulse and counter.

## Interface
- `ADDR_W`, default 3: register-bank address width; bank depth is `2**ADDR_W`.
- `DATA_W`, default 18: register-bank word width.
- `ERRCNT_W`, default 8: width of the saturating error counter.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `sen` input 1: frame enable, active-low; a frame is every cycle `sen`=0.
- `sd` input 1: serial data, MSB first, sampled when `sen`=0.
- `rb_rw` output 1: bank strobe; 1=read/idle, 0=write.
- `rb_a` output ADDR_W: bank address.
- `rb_d` output DATA_W: bank write data.
- `rb_q` input DATA_W: bank read data; unused, kept for port compatibility.
- `done` output 1: sticky; all `2**ADDR_W` addresses written.
- `frame_err` output 1: one-cycle pulse on a discarded frame.
- `err_cnt` output ERRCNT_W: saturating count of discarded frames.

## Operation
- Frame layout: `ADDR_W` address bits then `DATA_W` data bits, MSB first; `FRAME_W = ADDR_W+DATA_W` (+1 with parity).
- States: IDLE, SHIFT, WRITE, ERROR.
- IDLE: `sen`=0 -> capture bit, bit count=1, go SHIFT.
- SHIFT: `sen`=0 -> shift in `sd`, bit count+1 (saturates at FRAME_W+1); `sen`=1 -> go WRITE if count==FRAME_W (and parity good), else ERROR.
- WRITE (one cycle): `rb_rw`=0, `rb_a`/`rb_d` = captured fields; set bit `rb_a` in written-bitmap; next IDLE. If `sen`=0 in this cycle, bit is captured as first bit of next frame (go SHIFT, count=1).
- ERROR (one cycle): `frame_err`=1, `err_cnt`+1 saturating at all-ones, outputs `rb_a`/`rb_d` unchanged, no write; same `sen`=0 capture rule as WRITE.
- `done` sets in the cycle after the write that completes the bitmap; stays 1 until reset. Frames still accepted and written after `done`.
- Rewrites of an already-written address are legal; last write wins; bitmap unaffected.
- Too-long frames (count saturated) and too-short frames (including length 0 impossible; length 1..FRAME_W-1) -> ERROR.

## Timing
- Reset values: `rb_rw`=1, `rb_a`=0, `rb_d`=0, `done`=0, `frame_err`=0, `err_cnt`=0, bitmap=0, state IDLE.
- Latency: `rb_rw` low in the cycle after the first sampled `sen`=1 (registered output); exactly one cycle wide.
- `rb_a`/`rb_d` registered, stable from the write cycle until the next write.
- Back-to-back frames with a single `sen`=1 gap cycle are fully supported.
- Reset mid-frame: partial frame discarded, no write, no error count.

## Configuration
- `S2_RX_PARITY_EN` defined: frame carries one trailing even-parity bit over address+data; FRAME_W grows by 1; mismatch -> ERROR.
- Undefined: no parity bit; a frame of FRAME_W+1 bits is a length error.

## Structure
- Package `s2_rx_pkg`: state enum, `frame_w` function of ADDR_W/DATA_W and parity macro.
- Sub-module `s2_rx_shift`: shift register, saturating bit counter, parity accumulator; parent holds FSM, outputs, bitmap, error counter.

## Test plan
- Reset, then frame addr=5 data=0x2A5A5 -> one cycle `rb_rw`=0, `rb_a`=5, `rb_d`=0x2A5A5; `done`=0.
- Eight frames to addresses 0..7 with one-cycle gaps -> eight write pulses; `done`=1 the cycle after the eighth.
- Frame of 20 bits, then 22 bits -> two `frame_err` pulses, `err_cnt`=2, no write, `rb_a`/`rb_d` unchanged.
- Addresses 0..6 written twice, 7 never -> `done` stays 0; write 7 -> `done`=1.
- `rst` asserted after 10 bits, then a good frame -> only the good frame written, `err_cnt`=0.
- With `S2_RX_PARITY_EN`: addr=1 data=0x00001 parity 0 -> write; same with parity 1 -> `frame_err`, no write.
